mode_sequencer: RTL and testbench

//  Parametrised successor to the four-mode front-panel controller. Steps through NUM_MODES operating modes:
//   0 music box, 1 electone, 2 writing (UART entry), 3 playback; modes >=4 are idle.

---
 rtl/mode_sequencer.sv | 241 ++++++++++++++++++++++++
 tb/tb_mode_sequencer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mode_sequencer.sv
// Front-panel mode sequencer: steps through NUM_MODES engine modes, routes panel inputs, builds the display word.
// Latency: every output is registered; button pulses and rx bytes appear one cycle after they are sampled.
// Backpressure: none; mode_step/mode_back are dropped while a change is in progress, pulses are dropped while busy.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   mode_step / mode_back           one-cycle requests to move to the next / previous mode
//   sw, box_signal                  LED sources for electone / music-box modes
//   inc, dec                        button pulses, routed to box_next/box_pre (mode 0) or org_add/org_redu (mode 1)
//   box_sel, box_len, org_band      values shown on the display in modes 0 and 1
//   rx_byte, rx_valid               UART bytes collected into a 32-bit history in mode 2
//   quiesce_req / quiesce_ack       stop handshake with the engine that is being switched away from
//   mode, mode_oh, busy, flags      current mode state
//   led_bus, disp_data              LED and 7-seg display words
//
// Optional feature: define MODE_REV_EN to let mode_back step to the previous mode.
// Mode change sequence: RUN -> DRAIN (wait for ack or timeout) -> SWITCH (one cycle) -> SETTLE -> RUN.

module mode_sequencer #(
    parameter int NUM_MODES   = 4,
    parameter int ACK_TIMEOUT = 1023,
    parameter int SETTLE_CYC  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode_step,
    input  logic                 mode_back,
    input  logic [15:0]          sw,
    input  logic [15:0]          box_signal,
    input  logic                 inc,
    input  logic                 dec,
    input  logic [2:0]           box_sel,
    input  logic [2:0]           box_len,
    input  logic [2:0]           org_band,
    input  logic [7:0]           rx_byte,
    input  logic                 rx_valid,
    input  logic                 quiesce_ack,
    output logic                 quiesce_req,
    output logic [2:0]           mode,
    output logic [NUM_MODES-1:0] mode_oh,
    output logic                 busy,
    output logic                 music_box,
    output logic                 electone,
    output logic                 writing,
    output logic                 adj,
    output logic [15:0]          led_bus,
    output logic                 box_next,
    output logic                 box_pre,
    output logic                 org_add,
    output logic                 org_redu,
    output logic [31:0]          disp_data
);

    localparam int TW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
    localparam int SW = (SETTLE_CYC  < 2) ? 1 : $clog2(SETTLE_CYC + 1);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_SWITCH = 2'd2,
        S_SETTLE = 2'd3
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [2:0]            target;
    logic [2:0]            target_nxt;
    logic [TW-1:0]         timer;
    logic [TW-1:0]         timer_nxt;
    logic [SW-1:0]         settle_cnt;
    logic [SW-1:0]         settle_cnt_nxt;
    logic [31:0]           rx_hist;
    logic [31:0]           rx_hist_nxt;
    logic [2:0]            mode_nxt;
    logic [NUM_MODES-1:0]  mode_oh_nxt;
    logic [15:0]           led_nxt;
    logic [31:0]           disp_nxt;
    logic                  idle;

    logic                  change_req;
    logic [2:0]            change_tgt;
    logic [2:0]            mode_inc;

    assign idle     = (state == S_RUN);
    assign mode_inc = (mode == 3'(NUM_MODES - 1)) ? 3'd0 : mode + 3'd1;

`ifdef MODE_REV_EN
    logic [2:0] mode_dec;

    assign mode_dec   = (mode == 3'd0) ? 3'(NUM_MODES - 1) : mode - 3'd1;
    // Forward request wins when both arrive together.
    assign change_req = mode_step | mode_back;
    assign change_tgt = mode_step ? mode_inc : mode_dec;
`else
    logic unused_mode_back;

    assign unused_mode_back = mode_back;
    assign change_req       = mode_step;
    assign change_tgt       = mode_inc;
`endif

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_RUN;
            target     <= 3'd0;
            timer      <= '0;
            settle_cnt <= '0;
        end else begin
            state      <= state_nxt;
            target     <= target_nxt;
            timer      <= timer_nxt;
            settle_cnt <= settle_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt      = state;
        target_nxt     = target;
        timer_nxt      = timer;
        settle_cnt_nxt = settle_cnt;
        case (state)
            S_RUN: begin
                if (change_req) begin
                    state_nxt  = S_DRAIN;
                    target_nxt = change_tgt;
                    timer_nxt  = '0;
                end
            end
            S_DRAIN: begin
                // timer holds the number of DRAIN cycles already spent, so the
                // forced switch happens on the ACK_TIMEOUT-th DRAIN cycle.
                if (quiesce_ack || (timer == TW'(ACK_TIMEOUT - 1))) begin
                    state_nxt = S_SWITCH;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            S_SWITCH: begin
                state_nxt      = S_SETTLE;
                settle_cnt_nxt = '0;
            end
            S_SETTLE: begin
                if (settle_cnt == SW'(SETTLE_CYC - 1)) begin
                    state_nxt = S_RUN;
                end else begin
                    settle_cnt_nxt = settle_cnt + SW'(1);
                end
            end
            default: begin
                state_nxt = S_RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next values. Registered outputs are computed from the
    // next mode so that flags, one-hot and display change on the same
    // edge as mode itself.
    // ------------------------------------------------------------------
    always_comb begin
        mode_nxt = (state == S_SWITCH) ? target : mode;

        rx_hist_nxt = rx_hist;
        if (state == S_SWITCH) begin
            rx_hist_nxt = 32'd0;
        end else if (idle && (mode == 3'd2) && rx_valid) begin
            rx_hist_nxt = {rx_hist[23:0], rx_byte};
        end

        mode_oh_nxt = '0;
        for (int i = 0; i < NUM_MODES; i++) begin
            mode_oh_nxt[i] = (mode_nxt == 3'(i));
        end

        // LEDs freeze for the whole change, including the RUN->DRAIN edge.
        led_nxt = led_bus;
        if (state_nxt == S_RUN) begin
            case (mode_nxt)
                3'd0, 3'd3: led_nxt = box_signal;
                3'd1:       led_nxt = sw;
                3'd2:       led_nxt = {8'h00, rx_hist_nxt[7:0]};
                default:    led_nxt = 16'd0;
            endcase
        end

        case (mode_nxt)
            3'd0:    disp_nxt = {13'd0, box_len, 13'd0, box_sel};
            3'd1:    disp_nxt = {29'd0, org_band};
            3'd2:    disp_nxt = rx_hist_nxt;
            3'd3:    disp_nxt = 32'd0;
            default: disp_nxt = {29'd0, mode_nxt};
        endcase
    end

    // ------------------------------------------------------------------
    // Output and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode        <= 3'd0;
            mode_oh     <= NUM_MODES'(1);
            rx_hist     <= 32'd0;
            quiesce_req <= 1'b0;
            busy        <= 1'b0;
            music_box   <= 1'b1;
            electone    <= 1'b0;
            writing     <= 1'b0;
            adj         <= 1'b1;
            led_bus     <= 16'd0;
            box_next    <= 1'b0;
            box_pre     <= 1'b0;
            org_add     <= 1'b0;
            org_redu    <= 1'b0;
            disp_data   <= 32'd0;
        end else begin
            mode        <= mode_nxt;
            mode_oh     <= mode_oh_nxt;
            rx_hist     <= rx_hist_nxt;
            quiesce_req <= (state_nxt == S_DRAIN);
            busy        <= (state_nxt != S_RUN);
            music_box   <= (mode_nxt == 3'd0) || (mode_nxt == 3'd3);
            electone    <= (mode_nxt == 3'd1);
            writing     <= (mode_nxt == 3'd2) || (mode_nxt == 3'd3);
            adj         <= (mode_nxt == 3'd0);
            led_bus     <= led_nxt;
            // Pulses are routed only while RUN; mode is stable then.
            box_next    <= idle && (mode == 3'd0) && inc;
            box_pre     <= idle && (mode == 3'd0) && dec;
            org_add     <= idle && (mode == 3'd1) && inc;
            org_redu    <= idle && (mode == 3'd1) && dec;
            disp_data   <= disp_nxt;
        end
    end

endmodule

// File: tb/tb_mode_sequencer.sv
// Self-checking bench for mode_sequencer.
// Expected modes and display words are queued when stimulus is driven and compared when the DUT produces them.
// All inputs are driven, and outputs sampled, 1 time unit after the rising clock edge.

module tb_mode_sequencer;

    localparam int NM = 4;

    logic          clk;
    logic          rst_n;
    logic          mode_step;
    logic          mode_back;
    logic [15:0]   sw;
    logic [15:0]   box_signal;
    logic          inc;
    logic          dec;
    logic [2:0]    box_sel;
    logic [2:0]    box_len;
    logic [2:0]    org_band;
    logic [7:0]    rx_byte;
    logic          rx_valid;
    logic          quiesce_ack;
    logic          quiesce_req;
    logic [2:0]    mode;
    logic [NM-1:0] mode_oh;
    logic          busy;
    logic          music_box;
    logic          electone;
    logic          writing;
    logic          adj;
    logic [15:0]   led_bus;
    logic          box_next;
    logic          box_pre;
    logic          org_add;
    logic          org_redu;
    logic [31:0]   disp_data;

    int            n_checks;
    int            n_fail;
    int            model_mode;
    int            exp_mode_q[$];
    logic [31:0]   exp_disp_q[$];

    mode_sequencer #(
        .NUM_MODES   (NM),
        .ACK_TIMEOUT (1023),
        .SETTLE_CYC  (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mode_step   (mode_step),
        .mode_back   (mode_back),
        .sw          (sw),
        .box_signal  (box_signal),
        .inc         (inc),
        .dec         (dec),
        .box_sel     (box_sel),
        .box_len     (box_len),
        .org_band    (org_band),
        .rx_byte     (rx_byte),
        .rx_valid    (rx_valid),
        .quiesce_ack (quiesce_ack),
        .quiesce_req (quiesce_req),
        .mode        (mode),
        .mode_oh     (mode_oh),
        .busy        (busy),
        .music_box   (music_box),
        .electone    (electone),
        .writing     (writing),
        .adj         (adj),
        .led_bus     (led_bus),
        .box_next    (box_next),
        .box_pre     (box_pre),
        .org_add     (org_add),
        .org_redu    (org_redu),
        .disp_data   (disp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one change request and follow it until busy falls.
    // ack_delay < 0 means the engine never acknowledges.
    task automatic run_change(input logic stp, input logic bck, input int ack_delay,
                              output int q_cyc, output int tail_cyc, output bit timed_out,
                              output bit led_held);
        logic [15:0] led_before;
        int          exp_m;
        led_before = led_bus;
        exp_m = stp ? (model_mode + 1) % NM : (model_mode + NM - 1) % NM;
        exp_mode_q.push_back(exp_m);
        model_mode = exp_m;
        mode_step = stp;
        mode_back = bck;
        tick();
        mode_step = 1'b0;
        mode_back = 1'b0;
        q_cyc     = 0;
        tail_cyc  = 0;
        timed_out = 1'b1;
        led_held  = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            if (!busy) begin
                timed_out = 1'b0;
                break;
            end
            if (quiesce_req) q_cyc++;
            else tail_cyc++;
            if (led_bus !== led_before) led_held = 1'b0;
            if (ack_delay >= 0 && n + 1 == ack_delay) quiesce_ack = 1'b1;
            tick();
        end
        quiesce_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        mode_step = 0; mode_back = 0; inc = 0; dec = 0; rx_valid = 0; quiesce_ack = 0;
        rx_byte = 8'h00;
        sw = 16'hA5A5; box_signal = 16'h1234;
        box_sel = 3'd5; box_len = 3'd6; org_band = 3'd5;
        #2 rst_n = 1'b0;
        tick();
        tick();
        n_checks++; if (mode !== 3'd0) begin n_fail++; $display("FAIL reset_mode got %0d want 0", mode); end
        n_checks++; if (mode_oh !== 4'b0001) begin n_fail++; $display("FAIL reset_mode_oh got %b want 0001", mode_oh); end
        n_checks++; if (busy !== 1'b0 || quiesce_req !== 1'b0) begin n_fail++; $display("FAIL reset_busy_req got %b%b want 00", busy, quiesce_req); end
        n_checks++; if ({music_box, electone, writing, adj} !== 4'b1001) begin n_fail++; $display("FAIL reset_flags got %b want 1001", {music_box, electone, writing, adj}); end
        n_checks++; if (led_bus !== 16'h0 || disp_data !== 32'h0) begin n_fail++; $display("FAIL reset_led_disp got %h/%h want 0/0", led_bus, disp_data); end
        n_checks++; if ({box_next, box_pre, org_add, org_redu} !== 4'b0) begin n_fail++; $display("FAIL reset_pulses got %b want 0000", {box_next, box_pre, org_add, org_redu}); end
        rst_n = 1'b1;
        model_mode = 0;
        tick();
        n_checks++; if (led_bus !== 16'h1234) begin n_fail++; $display("FAIL mode0_led got %h want 1234", led_bus); end
        n_checks++; if (disp_data !== 32'h0006_0005) begin n_fail++; $display("FAIL mode0_disp got %h want 00060005", disp_data); end
    endtask

    task automatic test_step_ack();
        int q, t, e; bit to, held;
        run_change(1'b1, 1'b0, 2, q, t, to, held);
        n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL step_ack_timeout busy never fell"); end
        n_checks++; if (q != 2) begin n_fail++; $display("FAIL step_ack_req_cycles got %0d want 2", q); end
        n_checks++; if (t != 5) begin n_fail++; $display("FAIL step_ack_switch_settle got %0d want 5", t); end
        e = exp_mode_q.pop_front();
        n_checks++; if (mode !== 3'(e)) begin n_fail++; $display("FAIL step_ack_mode got %0d want %0d", mode, e); end
        n_checks++; if ({music_box, electone, writing, adj} !== 4'b0100) begin n_fail++; $display("FAIL mode1_flags got %b want 0100", {music_box, electone, writing, adj}); end
        n_checks++; if (mode_oh !== 4'b0010) begin n_fail++; $display("FAIL mode1_oh got %b want 0010", mode_oh); end
        n_checks++; if (held !== 1'b1) begin n_fail++; $display("FAIL led_hold_busy changed while busy, want held"); end
        n_checks++; if (led_bus !== 16'hA5A5) begin n_fail++; $display("FAIL mode1_led got %h want a5a5", led_bus); end
        n_checks++; if (disp_data !== 32'd5) begin n_fail++; $display("FAIL mode1_disp got %h want 5", disp_data); end
        inc = 1'b1; tick(); inc = 1'b0;
        n_checks++; if ({org_add, box_next} !== 2'b10) begin n_fail++; $display("FAIL mode1_inc got %b want 10", {org_add, box_next}); end
        dec = 1'b1; tick(); dec = 1'b0;
        n_checks++; if ({org_redu, org_add, box_pre} !== 3'b100) begin n_fail++; $display("FAIL mode1_dec got %b want 100", {org_redu, org_add, box_pre}); end
    endtask

    task automatic test_timeout();
        int q, t, e; bit to, held;
        run_change(1'b1, 1'b0, -1, q, t, to, held);
        n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL timeout_done busy never fell"); end
        n_checks++; if (q != 1023) begin n_fail++; $display("FAIL timeout_drain_cycles got %0d want 1023", q); end
        e = exp_mode_q.pop_front();
        n_checks++; if (mode !== 3'(e)) begin n_fail++; $display("FAIL timeout_mode got %0d want %0d", mode, e); end
        n_checks++; if ({music_box, electone, writing} !== 3'b001) begin n_fail++; $display("FAIL mode2_flags got %b want 001", {music_box, electone, writing}); end
    endtask

    task automatic test_rx();
        logic [31:0] hist;
        logic [31:0] exp_d;
        logic [7:0]  bytes [3];
        bytes[0] = 8'h41; bytes[1] = 8'h42; bytes[2] = 8'h43;
        hist = 32'h0;
        for (int i = 0; i < 3; i++) begin
            rx_byte  = bytes[i];
            rx_valid = 1'b1;
            hist = {hist[23:0], bytes[i]};
            exp_disp_q.push_back(hist);
            tick();
            rx_valid = 1'b0;
            exp_d = exp_disp_q.pop_front();
            n_checks++; if (disp_data !== exp_d) begin n_fail++; $display("FAIL rx_disp_%0d got %h want %h", i, disp_data, exp_d); end
            tick();
        end
        n_checks++; if (disp_data !== 32'h0041_4243) begin n_fail++; $display("FAIL rx_final_disp got %h want 00414243", disp_data); end
        n_checks++; if (led_bus !== 16'h0043) begin n_fail++; $display("FAIL rx_led got %h want 0043", led_bus); end
        inc = 1'b1; tick(); inc = 1'b0;
        n_checks++; if ({box_next, org_add} !== 2'b00) begin n_fail++; $display("FAIL mode2_inc_dropped got %b want 00", {box_next, org_add}); end
    endtask

    task automatic test_wrap_busy();
        int q, t, e; bit to, held, saw_pulse;
        run_change(1'b1, 1'b0, 1, q, t, to, held);
        e = exp_mode_q.pop_front();
        n_checks++; if (mode !== 3'(e) || to) begin n_fail++; $display("FAIL to_mode3 got %0d want %0d", mode, e); end
        n_checks++; if ({music_box, writing, disp_data} !== {2'b11, 32'h0}) begin n_fail++; $display("FAIL mode3_outputs got %b%b/%h want 11/0", music_box, writing, disp_data); end
        // Wrap 3 -> 0 with an extra step while busy and inc during SETTLE.
        exp_mode_q.push_back(0);
        model_mode = 0;
        mode_step = 1'b1; tick(); mode_step = 1'b0;
        mode_step = 1'b1; tick(); mode_step = 1'b0;
        quiesce_ack = 1'b1; tick(); quiesce_ack = 1'b0;
        tick();
        inc = 1'b1; tick(); inc = 1'b0;
        saw_pulse = box_next;
        to = 1'b1;
        for (int n = 0; n < 20; n++) begin
            if (!busy) begin to = 1'b0; break; end
            tick();
            if (box_next) saw_pulse = 1'b1;
        end
        e = exp_mode_q.pop_front();
        n_checks++; if (mode !== 3'(e) || to) begin n_fail++; $display("FAIL wrap_mode got %0d want %0d", mode, e); end
        n_checks++; if (saw_pulse !== 1'b0) begin n_fail++; $display("FAIL settle_inc got box_next=1 want 0"); end
        tick(); tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_step_ignored got busy=%b want 0", busy); end
        inc = 1'b1; tick(); inc = 1'b0;
        n_checks++; if (box_next !== 1'b1) begin n_fail++; $display("FAIL run_inc got %b want 1", box_next); end
        tick();
        n_checks++; if (box_next !== 1'b0) begin n_fail++; $display("FAIL run_inc_single got %b want 0", box_next); end
    endtask

`ifdef MODE_REV_EN
    task automatic test_mode_back();
        int q, t, e; bit to, held;
        run_change(1'b1, 1'b1, 1, q, t, to, held);
        e = exp_mode_q.pop_front();
        n_checks++; if (mode !== 3'(e) || to) begin n_fail++; $display("FAIL step_wins got %0d want %0d", mode, e); end
        run_change(1'b0, 1'b1, 1, q, t, to, held);
        e = exp_mode_q.pop_front();
        n_checks++; if (mode !== 3'(e) || to) begin n_fail++; $display("FAIL back_1_0 got %0d want %0d", mode, e); end
        run_change(1'b0, 1'b1, 1, q, t, to, held);
        e = exp_mode_q.pop_front();
        n_checks++; if (mode !== 3'(e) || to) begin n_fail++; $display("FAIL back_wrap got %0d want %0d", mode, e); end
    endtask
`else
    task automatic test_mode_back();
        mode_back = 1'b1; tick(); mode_back = 1'b0;
        n_checks++; if (busy !== 1'b0 || quiesce_req !== 1'b0) begin n_fail++; $display("FAIL back_ignored got busy=%b req=%b want 0 0", busy, quiesce_req); end
        n_checks++; if (mode !== 3'(model_mode)) begin n_fail++; $display("FAIL back_ignored_mode got %0d want %0d", mode, model_mode); end
    endtask
`endif

    task automatic test_reset_mid_drain();
        int q, t, e; bit to, held;
        for (int k = 0; k < NM && model_mode != 1; k++) begin
            run_change(1'b1, 1'b0, 1, q, t, to, held);
            e = exp_mode_q.pop_front();
            n_checks++; if (mode !== 3'(e) || to) begin n_fail++; $display("FAIL pre_reset_mode got %0d want %0d", mode, e); end
        end
        mode_step = 1'b1; tick(); mode_step = 1'b0;
        tick(); tick();
        n_checks++; if (quiesce_req !== 1'b1 || disp_data !== 32'd5) begin n_fail++; $display("FAIL drain_before_reset got req=%b disp=%h want 1/5", quiesce_req, disp_data); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (quiesce_req !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_req got %b%b want 00", quiesce_req, busy); end
        n_checks++; if (mode !== 3'd0 || mode_oh !== 4'b0001) begin n_fail++; $display("FAIL mid_reset_mode got %0d/%b want 0/0001", mode, mode_oh); end
        n_checks++; if (disp_data !== 32'h0) begin n_fail++; $display("FAIL mid_reset_disp got %h want 0", disp_data); end
        tick();
        rst_n = 1'b1;
        model_mode = 0;
        exp_mode_q.delete();
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_step_ack();
        test_timeout();
        test_rx();
        test_wrap_busy();
        test_mode_back();
        test_reset_mid_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
